// File: rtl/tdm_mux_tx_if.sv
// Parallel-word handshake and serial slot outputs of the TDM transmitter.
interface tdm_mux_tx_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned SEL_W  = 2
);
    logic [NUM_CH-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              tdm_out;
    logic [SEL_W-1:0]  tdm_sel;
    logic              slot_valid;
    logic              frame_sync;
    logic              busy;

    // Upstream producer / downstream observer side
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  tdm_out,
        input  tdm_sel,
        input  slot_valid,
        input  frame_sync,
        input  busy
    );

    // Transmitter side
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output tdm_out,
        output tdm_sel,
        output slot_valid,
        output frame_sync,
        output busy
    );
endinterface

// File: rtl/tdm_mux_tx.sv
// TDM transmitter: serialises one NUM_CH-bit word per frame, one channel bit
// per clock, with a one-deep holding buffer so frames run back-to-back.
module tdm_mux_tx #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned SEL_W  = 2
) (
    input  logic        clk,
    input  logic        rst,
    tdm_mux_tx_if.slave bus
);
    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NUM_CH - 1);

    // Reject parameter combinations the slot counter cannot represent
    if (NUM_CH < 2 || NUM_CH > 16 || SEL_W != $clog2(NUM_CH)) begin : g_param_check
        $error("tdm_mux_tx: illegal NUM_CH/SEL_W combination");
    end

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  slot_q, slot_d;
    logic [NUM_CH-1:0] active_q, active_d;
    logic [NUM_CH-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;

    // Output registers; their next values are decoded from next-state so the
    // ports track the current slot with no combinational path from inputs.
    logic              tdm_out_q, tdm_out_d;
    logic [SEL_W-1:0]  tdm_sel_q, tdm_sel_d;
    logic              slot_valid_q, slot_valid_d;
    logic              frame_sync_q, frame_sync_d;
    logic              busy_q, busy_d;
    logic              in_ready_q, in_ready_d;

    logic              accept;
    logic              load_pt;
    logic              send_d;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, datapath and output decode
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        active_d     = active_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        tdm_out_d    = 1'b0;
        tdm_sel_d    = '0;
        slot_valid_d = 1'b0;
        frame_sync_d = 1'b0;
        busy_d       = 1'b0;
        in_ready_d   = 1'b1;

        accept  = bus.in_valid & ~hold_full_q;
        load_pt = (state_q == IDLE) || ((state_q == SEND) && (slot_q == LAST_SLOT));

        if (load_pt) begin
            slot_d = '0;
            if (hold_full_q) begin
                // Held word takes over; in_ready is low so nothing new arrives
                active_d    = hold_q;
                hold_full_d = 1'b0;
                state_d     = SEND;
            end else if (accept) begin
                // Bypass straight into the active frame
                active_d = bus.in_data;
                state_d  = SEND;
            end else begin
                state_d = IDLE;
            end
        end else begin
            slot_d = slot_q + SEL_W'(1);
            if (accept) begin
                hold_d      = bus.in_data;
                hold_full_d = 1'b1;
            end
        end

        send_d       = (state_d == SEND);
        slot_valid_d = send_d;
        tdm_sel_d    = send_d ? slot_d : '0;
        tdm_out_d    = send_d & active_d[slot_d];
        frame_sync_d = send_d & (slot_d == '0);
        busy_d       = send_d | hold_full_d;
        in_ready_d   = ~hold_full_d;
    end

    // Datapath and output registers; reset discards any frame in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q       <= '0;
            active_q     <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            tdm_out_q    <= 1'b0;
            tdm_sel_q    <= '0;
            slot_valid_q <= 1'b0;
            frame_sync_q <= 1'b0;
            busy_q       <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            slot_q       <= slot_d;
            active_q     <= active_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            tdm_out_q    <= tdm_out_d;
            tdm_sel_q    <= tdm_sel_d;
            slot_valid_q <= slot_valid_d;
            frame_sync_q <= frame_sync_d;
            busy_q       <= busy_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.tdm_out    = tdm_out_q;
    assign bus.tdm_sel    = tdm_sel_q;
    assign bus.slot_valid = slot_valid_q;
    assign bus.frame_sync = frame_sync_q;
    assign bus.busy       = busy_q;
    assign bus.in_ready   = in_ready_q;

endmodule

// File: tb/tb_tdm_mux_tx.sv
// Bench for tdm_mux_tx: a 4-channel and a 2-channel instance, each with a
// slot scoreboard filled at accept time and drained by a monitor.
module tb_tdm_mux_tx;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    tdm_mux_tx_if #(.NUM_CH(4), .SEL_W(2)) b4 ();
    tdm_mux_tx_if #(.NUM_CH(2), .SEL_W(1)) b2 ();

    tdm_mux_tx #(.NUM_CH(4), .SEL_W(2)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));
    tdm_mux_tx #(.NUM_CH(2), .SEL_W(1)) u_dut2 (.clk(clk), .rst(rst), .bus(b2));

    typedef struct {
        logic        d;
        int unsigned sel;
        logic        fs;
    } slot_t;

    slot_t q4[$];
    slot_t q2[$];
    int    n_chk     = 0;
    int    n_fail    = 0;
    int    run4      = 0;
    int    last_run4 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame4(input logic [3:0] w);
        slot_t s;
        for (int k = 0; k < 4; k++) begin
            s.d = w[k]; s.sel = k; s.fs = (k == 0);
            q4.push_back(s);
        end
    endtask

    task automatic push_frame2(input logic [1:0] w);
        slot_t s;
        for (int k = 0; k < 2; k++) begin
            s.d = w[k]; s.sel = k; s.fs = (k == 0);
            q2.push_back(s);
        end
    endtask

    // Present a word and hold it until accepted; waits = cycles stalled
    task automatic send4(input logic [3:0] w, output int waits);
        waits = 0;
        b4.in_data  = w;
        b4.in_valid = 1'b1;
        while (!b4.in_ready && waits < 40) begin
            tick();
            waits++;
        end
        if (!b4.in_ready) begin
            n_chk++; n_fail++;
            $display("FAIL send4_timeout: in_ready stuck at 0 for word %b", w);
        end else begin
            push_frame4(w);
        end
        tick();
        b4.in_valid = 1'b0;
    endtask

    task automatic send2(input logic [1:0] w, output int waits);
        waits = 0;
        b2.in_data  = w;
        b2.in_valid = 1'b1;
        while (!b2.in_ready && waits < 40) begin
            tick();
            waits++;
        end
        if (!b2.in_ready) begin
            n_chk++; n_fail++;
            $display("FAIL send2_timeout: in_ready stuck at 0 for word %b", w);
        end else begin
            push_frame2(w);
        end
        tick();
        b2.in_valid = 1'b0;
    endtask

    task automatic reset_checks();
        chk("rst_in_ready4",   32'(b4.in_ready),   32'd1);
        chk("rst_slot_valid4", 32'(b4.slot_valid), 32'd0);
        chk("rst_busy4",       32'(b4.busy),       32'd0);
        chk("rst_tdm_out4",    32'(b4.tdm_out),    32'd0);
        chk("rst_tdm_sel4",    32'(b4.tdm_sel),    32'd0);
        chk("rst_sync4",       32'(b4.frame_sync), 32'd0);
        chk("rst_in_ready2",   32'(b2.in_ready),   32'd1);
        chk("rst_slot_valid2", 32'(b2.slot_valid), 32'd0);
    endtask

    // Scoreboard monitor, 4-channel instance; also tracks slot run lengths
    always @(negedge clk) begin
        if (!rst) begin
            if (b4.slot_valid) begin
                run4++;
                if (q4.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL sb4_underflow: unexpected slot sel=%0d out=%0b", b4.tdm_sel, b4.tdm_out);
                end else begin
                    slot_t e;
                    e = q4.pop_front();
                    chk("sb4_out",  32'(b4.tdm_out),    32'(e.d));
                    chk("sb4_sel",  32'(b4.tdm_sel),    e.sel);
                    chk("sb4_sync", 32'(b4.frame_sync), 32'(e.fs));
                end
            end else begin
                if (run4 != 0) last_run4 = run4;
                run4 = 0;
            end
        end
    end

    // Scoreboard monitor, 2-channel instance
    always @(negedge clk) begin
        if (!rst && b2.slot_valid) begin
            if (q2.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL sb2_underflow: unexpected slot sel=%0d out=%0b", b2.tdm_sel, b2.tdm_out);
            end else begin
                slot_t e;
                e = q2.pop_front();
                chk("sb2_out",  32'(b2.tdm_out),    32'(e.d));
                chk("sb2_sel",  32'(b2.tdm_sel),    e.sel);
                chk("sb2_sync", 32'(b2.frame_sync), 32'(e.fs));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, w1, w2;
        rst = 1'b1;
        b4.in_valid = 1'b0; b4.in_data = '0;
        b2.in_valid = 1'b0; b2.in_data = '0;
        repeat (2) tick();

        // Reset holds outputs quiet even with in_valid asserted
        b4.in_valid = 1'b1; b4.in_data = 4'b1010;
        b2.in_valid = 1'b1; b2.in_data = 2'b11;
        repeat (3) begin
            tick();
            reset_checks();
        end
        b4.in_valid = 1'b0;
        b2.in_valid = 1'b0;
        rst = 1'b0;
        tick();

        // Single frame 1011: slot 0 right after accept, idle after slot 3
        send4(4'b1011, w0);
        chk("t1_slot0_valid", 32'(b4.slot_valid), 32'd1);
        chk("t1_slot0_sync",  32'(b4.frame_sync), 32'd1);
        chk("t1_slot0_out",   32'(b4.tdm_out),    32'd1);
        chk("t1_busy",        32'(b4.busy),       32'd1);
        repeat (3) tick();
        chk("t1_slot3_sel",   32'(b4.tdm_sel),    32'd3);
        chk("t1_slot3_out",   32'(b4.tdm_out),    32'd1);
        chk("t1_slot3_sync",  32'(b4.frame_sync), 32'd0);
        tick();
        chk("t1_end_valid",   32'(b4.slot_valid), 32'd0);
        chk("t1_end_busy",    32'(b4.busy),       32'd0);
        tick();
        chk("t1_run_len",     32'(last_run4),     32'd4);

        // Back-to-back with backpressure: third word stalls three cycles
        send4(4'b0101, w0);
        send4(4'b1110, w1);
        send4(4'b0011, w2);
        chk("t2_w0_wait", 32'(w0), 32'd0);
        chk("t2_w1_wait", 32'(w1), 32'd0);
        chk("t2_w2_wait", 32'(w2), 32'd3);
        repeat (14) tick();
        chk("t2_run_len", 32'(last_run4), 32'd12);
        chk("t2_idle_busy", 32'(b4.busy), 32'd0);

        // Reset during slot 2 of 1111 with 0001 held
        send4(4'b1111, w0);
        send4(4'b0001, w1);
        tick();
        chk("t3_pre_sel",   32'(b4.tdm_sel),  32'd2);
        chk("t3_pre_ready", 32'(b4.in_ready), 32'd0);
        chk("t3_pre_busy",  32'(b4.busy),     32'd1);
        rst = 1'b1;
        q4.delete();
        b4.in_valid = 1'b1; b4.in_data = 4'b1010;
        #1;
        reset_checks();
        repeat (2) begin
            tick();
            reset_checks();
        end
        b4.in_valid = 1'b0;
        rst = 1'b0;
        repeat (6) begin
            tick();
            chk("t3_post_idle", 32'(b4.slot_valid), 32'd0);
        end
        chk("t3_post_busy", 32'(b4.busy), 32'd0);
        send4(4'b0110, w0);
        chk("t3_new_sync", 32'(b4.frame_sync), 32'd1);
        chk("t3_new_out0", 32'(b4.tdm_out),    32'd0);
        tick();
        chk("t3_new_out1", 32'(b4.tdm_out),    32'd1);
        repeat (6) tick();

        // Two-channel instance: 10 goes out as 0 then 1
        send2(2'b10, w0);
        chk("s2_slot0_sel", 32'(b2.tdm_sel),    32'd0);
        chk("s2_slot0_out", 32'(b2.tdm_out),    32'd0);
        chk("s2_slot0_syn", 32'(b2.frame_sync), 32'd1);
        tick();
        chk("s2_slot1_sel", 32'(b2.tdm_sel),    32'd1);
        chk("s2_slot1_out", 32'(b2.tdm_out),    32'd1);
        tick();
        chk("s2_end_valid", 32'(b2.slot_valid), 32'd0);
        tick();

        // Streaming with gaps and unaccepted in_valid pulses
        for (int i = 0; i < 1000; i++) begin
            if (!b2.in_ready && ($urandom_range(0, 3) == 0)) begin
                b2.in_data  = 2'($urandom);
                b2.in_valid = 1'b1;
                tick();
                b2.in_valid = 1'b0;
            end
            send2(2'($urandom), w0);
            if ($urandom_range(0, 3) == 0) tick();
        end

        repeat (10) tick();
        chk("q4_drained", 32'(q4.size()), 32'd0);
        chk("q2_drained", 32'(q2.size()), 32'd0);
        chk("end_busy4",  32'(b4.busy),   32'd0);
        chk("end_busy2",  32'(b2.busy),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
